// File: rtl/attn_inst_sequencer.sv
// Instruction sequencer for fullchip: one start runs K/S load, execute, ofifo->pmem move
// and pmem readout, with ofifo flow control, abort and QK/SV mode select.
module attn_inst_sequencer #(
  parameter int ROWS   = 8,
  parameter int COL    = 8,
  parameter int GAP    = 10,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic              ofifo_valid,
  output logic [19:0]       inst,
  output logic              busy,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_row,
  output logic              done
);

  localparam int GW = $clog2(GAP + RD_LAT + 1);
  localparam int CW = (GW > ADDR_W + 1) ? GW : ADDR_W + 1;

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] TWO    = CW'(2);
  localparam logic [CW-1:0] COL_C  = CW'(COL);
  localparam logic [CW-1:0] ROWS_C = CW'(ROWS);
  localparam logic [CW-1:0] ROWS1  = CW'(ROWS - 1);
  localparam logic [CW-1:0] GAP1   = CW'(GAP - 1);
  localparam logic [CW-1:0] LAT2   = CW'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  typedef enum logic [3:0] {
    IDLE, KLOAD, KDRAIN, GAP_A, EXEC, GAP_B, MOVE, READ, RWAIT, DONE
  } state_t;

  typedef struct packed {
    logic       norm_v_rd;
    logic       ofifo_rd;
    logic [4:0] qk_add;
    logic [4:0] p_add;
    logic       execute;
    logic       load;
    logic       qmem_rd;
    logic       qmem_wr;
    logic       kmem_rd;
    logic       kmem_wr;
    logic       pmem_rd;
    logic       pmem_wr;
  } inst_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mode_q, move_en_q;
  inst_t inst_q, inst_d, inst_out;
  logic [RD_LAT:1] vld_pipe;
  logic [RD_LAT:1][ADDR_W-1:0] row_pipe;

  logic xfer, start_acc, abort_act;
  assign xfer      = move_en_q & ofifo_valid;
  assign start_acc = (state_q == IDLE) & start & ~abort;
  assign abort_act = (state_q != IDLE) & abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort_act) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start_acc) begin state_d = KLOAD; cnt_d = '0; end
        KLOAD:
          if (cnt_q == COL_C) begin state_d = KDRAIN; cnt_d = '0; end
          else cnt_d = cnt_q + ONE;
        KDRAIN:
          if (cnt_q == ONE) begin state_d = GAP_A; cnt_d = '0; end
          else cnt_d = cnt_q + ONE;
        GAP_A:
          if (cnt_q == GAP1) begin state_d = EXEC; cnt_d = '0; end
          else cnt_d = cnt_q + ONE;
        EXEC:
          if (cnt_q == ROWS1) begin state_d = GAP_B; cnt_d = '0; end
          else cnt_d = cnt_q + ONE;
        GAP_B:
          if (cnt_q == GAP1) begin state_d = MOVE; cnt_d = '0; end
          else cnt_d = cnt_q + ONE;
        // count only completed transfers; a stalled ofifo just holds the count
        MOVE:
          if (xfer) begin
            if (cnt_q == ROWS1) begin state_d = READ; cnt_d = '0; end
            else cnt_d = cnt_q + ONE;
          end
        READ:
          if (cnt_q == ROWS_C) begin
            state_d = (RD_LAT > 1) ? RWAIT : DONE;
            cnt_d   = '0;
          end else cnt_d = cnt_q + ONE;
        // lets the last read beat leave the latency pipe before done
        RWAIT:
          if (cnt_q == LAT2) begin state_d = DONE; cnt_d = '0; end
          else cnt_d = cnt_q + ONE;
        DONE:    begin state_d = IDLE; cnt_d = '0; end
        default: begin state_d = IDLE; cnt_d = '0; end
      endcase
    end
  end

  // inst is registered, so it is built from the state/count about to be entered
  always_comb begin
    inst_d = '0;
    case (state_d)
      KLOAD: begin
        inst_d.load    = 1'b1;
        inst_d.kmem_rd = (cnt_d != '0);
        inst_d.qk_add  = (cnt_d < TWO) ? 5'd0 : 5'(cnt_d - ONE);
      end
      KDRAIN: inst_d.load = (cnt_d == '0);
      EXEC: begin
        inst_d.execute = 1'b1;
        inst_d.qmem_rd = 1'b1;
        inst_d.qk_add  = 5'(cnt_d);
      end
      MOVE: inst_d.p_add = 5'(cnt_d);
      READ: begin
        inst_d.p_add = 5'(cnt_d);
        if (cnt_d < ROWS_C) begin
          inst_d.pmem_rd   = 1'b1;
          inst_d.norm_v_rd = mode_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      move_en_q <= 1'b0;
      inst_q    <= '0;
      vld_pipe  <= '0;
      row_pipe  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      inst_q    <= inst_d;
      move_en_q <= (state_d == MOVE);
      if (start_acc) mode_q <= mode;
      if (abort_act) begin
        vld_pipe <= '0;
        row_pipe <= '0;
      end else begin
        vld_pipe[1] <= inst_q.pmem_rd;
        row_pipe[1] <= ADDR_W'(inst_q.p_add);
        for (int i = 2; i <= RD_LAT; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          row_pipe[i] <= row_pipe[i-1];
        end
      end
    end
  end

  always_comb begin
    inst_out          = inst_q;
    inst_out.ofifo_rd = xfer;
    inst_out.pmem_wr  = xfer;
  end

  assign inst      = inst_out;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign out_valid = vld_pipe[RD_LAT];
  assign out_row   = row_pipe[RD_LAT];

endmodule
